// File: rtl/weight_buffer_streamer.sv
// Ping-pong weight buffer consumer: reads the filled bank through a
// 1-cycle-latency read port and streams it to the PE array via valid/ready.
// Optional feature macro: WSTREAM_REPEAT_EN (honour cfg_repeat per bank).
`timescale 1ns/1ps

module weight_buffer_streamer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BUF_AW     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fill_done,
    input  logic                  fill_sel,
    input  logic [BUF_AW:0]       fill_count,
    input  logic [7:0]            cfg_repeat,
    output logic [1:0]            bank_free,
    output logic                  bank_release,
    output logic                  release_sel,
    output logic                  buf_rd_en,
    output logic                  buf_rd_sel,
    output logic [BUF_AW-1:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  ovf_err
);

    localparam int unsigned CW  = BUF_AW + 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW = PW + 1;
    localparam int unsigned OCW = PW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_RELEASE
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    state_t            state_q;
    logic              cur_bank_q;
    logic [1:0]        bank_full_q;
    logic [CW-1:0]     fill_cnt_q [2];
    logic [CW-1:0]     cnt_q;
    logic [7:0]        rep_q;
    logic [BUF_AW-1:0] addr_q;
    logic              rd_en_q;
    logic              rd_sel_q;
    logic [BUF_AW-1:0] rd_addr_q;
    logic              rd_last_q;
    logic              pend_q;
    logic              pend_last_q;
    logic              release_q;
    logic              release_sel_q;
    logic              ovf_q;

    fifo_entry_t       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [FCW-1:0]    count_q;

    logic              pop_c;
    logic              push_c;
    logic [OCW-1:0]    occ_c;
    logic              issue_ok_c;
    logic              at_end_c;
    logic              drained_c;
    logic [7:0]        rep_start_c;

`ifdef WSTREAM_REPEAT_EN
    assign rep_start_c = (cfg_repeat == 8'd0) ? 8'd1 : cfg_repeat;
`else
    logic unused_cfg_repeat;
    assign unused_cfg_repeat = ^cfg_repeat;
    assign rep_start_c       = 8'd1;
`endif

    // Flow control: a new read may issue only if it is guaranteed a FIFO slot on return
    always_comb begin
        pop_c      = out_valid & out_ready;
        push_c     = pend_q;
        occ_c      = OCW'(count_q) + OCW'(rd_en_q) + OCW'(pend_q) - OCW'(pop_c);
        issue_ok_c = (occ_c < OCW'(FIFO_DEPTH));
        at_end_c   = (CW'(addr_q) == (cnt_q - CW'(1)));
        drained_c  = !rd_en_q && !pend_q && (count_q == FCW'(pop_c));
    end

    // Bank bookkeeping, streaming FSM and registered read-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cur_bank_q    <= 1'b0;
            bank_full_q   <= 2'b00;
            fill_cnt_q    <= '{default: '0};
            cnt_q         <= '0;
            rep_q         <= 8'd0;
            addr_q        <= '0;
            rd_en_q       <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_last_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_last_q   <= 1'b0;
            release_q     <= 1'b0;
            release_sel_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            release_q   <= 1'b0;
            pend_q      <= rd_en_q;
            pend_last_q <= rd_last_q;

            case (state_q)
                S_IDLE: begin
                    if (bank_full_q[cur_bank_q]) begin
                        cnt_q   <= fill_cnt_q[cur_bank_q];
                        rep_q   <= rep_start_c;
                        addr_q  <= '0;
                        state_q <= (fill_cnt_q[cur_bank_q] == '0) ? S_RELEASE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue_ok_c) begin
                        rd_en_q   <= 1'b1;
                        rd_sel_q  <= cur_bank_q;
                        rd_addr_q <= addr_q;
                        rd_last_q <= at_end_c && (rep_q <= 8'd1);
                        if (at_end_c) begin
                            if (rep_q > 8'd1) begin
                                addr_q <= '0;
                                rep_q  <= rep_q - 8'd1;
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            addr_q <= addr_q + BUF_AW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained_c) begin
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    bank_full_q[cur_bank_q] <= 1'b0;
                    release_q               <= 1'b1;
                    release_sel_q           <= cur_bank_q;
                    cur_bank_q              <= ~cur_bank_q;
                    state_q                 <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // A fill for a bank still marked full (including the one being released) is an overflow
            if (fill_done) begin
                if (bank_full_q[fill_sel]) begin
                    ovf_q <= 1'b1;
                end else begin
                    bank_full_q[fill_sel] <= 1'b1;
                    fill_cnt_q[fill_sel]  <= fill_count;
                end
            end
        end
    end

    // Output skid FIFO: captures read data one cycle after the strobe, tagged with the final-word bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= '{last: pend_last_q, data: buf_rd_data};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + FCW'(push_c) - FCW'(pop_c);
        end
    end

    assign bank_free    = ~bank_full_q;
    assign bank_release = release_q;
    assign release_sel  = release_sel_q;
    assign buf_rd_en    = rd_en_q;
    assign buf_rd_sel   = rd_sel_q;
    assign buf_rd_addr  = rd_addr_q;
    assign ovf_err      = ovf_q;
    assign out_valid    = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q].data;
    assign out_last     = out_valid & mem_q[rd_ptr_q].last;

endmodule
